// File: rtl/key_entry_ctrl.sv
// Keypad entry sequencer for the alarm clock HH:MM key buffer: range-checks
// digits by position, issues time/alarm load pulses and flushes the buffer.
module key_entry_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
    parameter int unsigned TMO_W          = 26
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] key,
    input  logic       key_valid,
    output logic       shift,
    output logic [3:0] key_out,
    output logic       load_time,
    output logic       load_alarm,
    output logic       key_err,
    output logic       timeout,
    output logic [2:0] digit_cnt
);

    localparam int unsigned KEY_W = 4;
    localparam int unsigned CNT_W = 3;
    localparam int unsigned CLR_W = 2;

    localparam logic [KEY_W-1:0] KEY_CLEAR     = 4'hA;
    localparam logic [KEY_W-1:0] KEY_SET_TIME  = 4'hB;
    localparam logic [KEY_W-1:0] KEY_SET_ALARM = 4'hC;
    localparam logic [TMO_W-1:0] TMO_LAST      = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENTRY,
        S_READY,
        S_LOAD,
        S_CLEAR
    } state_t;

    state_t             r_state;
    logic               r_shift;
    logic [KEY_W-1:0]   r_key_out;
    logic               r_load_time;
    logic               r_load_alarm;
    logic               r_key_err;
    logic               r_timeout;
    logic [CNT_W-1:0]   r_digit_cnt;
    logic [KEY_W-1:0]   r_first;
    logic [TMO_W-1:0]   r_tmo;
    logic [CLR_W-1:0]   r_clr_cnt;

    state_t             w_state_nxt;
    logic               w_shift_nxt;
    logic [KEY_W-1:0]   w_key_out_nxt;
    logic               w_load_time_nxt;
    logic               w_load_alarm_nxt;
    logic               w_key_err_nxt;
    logic               w_timeout_nxt;
    logic [CNT_W-1:0]   w_digit_cnt_nxt;
    logic [KEY_W-1:0]   w_first_nxt;
    logic [TMO_W-1:0]   w_tmo_nxt;
    logic [CLR_W-1:0]   w_clr_cnt_nxt;
    logic               w_is_digit;
    logic               w_accept;
    logic               w_in_entry;
    logic               w_nxt_in_entry;

    assign w_is_digit = (key <= 4'd9);

    // HH:MM range check for the slot the next digit would occupy
    always_comb begin
        w_accept = 1'b0;
        unique case (r_digit_cnt)
            3'd0:    w_accept = (key <= 4'd2);
            3'd1:    w_accept = (r_first == 4'd2) ? (key <= 4'd3) : (key <= 4'd9);
            3'd2:    w_accept = (key <= 4'd5);
            3'd3:    w_accept = (key <= 4'd9);
            default: w_accept = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_shift_nxt      = 1'b0;
        w_key_out_nxt    = '0;
        w_load_time_nxt  = 1'b0;
        w_load_alarm_nxt = 1'b0;
        w_key_err_nxt    = 1'b0;
        w_timeout_nxt    = 1'b0;
        w_digit_cnt_nxt  = r_digit_cnt;
        w_first_nxt      = r_first;
        w_clr_cnt_nxt    = r_clr_cnt;

        unique case (r_state)
            S_IDLE, S_ENTRY: begin
                if (key_valid) begin
                    if (w_is_digit) begin
                        if (w_accept) begin
                            w_shift_nxt     = 1'b1;
                            w_key_out_nxt   = key;
                            w_digit_cnt_nxt = r_digit_cnt + CNT_W'(1);
                            if (r_digit_cnt == 3'd0) begin
                                w_first_nxt = key;
                            end
                            w_state_nxt = (r_digit_cnt == 3'd3) ? S_READY : S_ENTRY;
                        end else begin
                            w_key_err_nxt = 1'b1;
                        end
                    end else if (key == KEY_CLEAR) begin
                        w_state_nxt   = S_CLEAR;
                        w_shift_nxt   = 1'b1;
                        w_clr_cnt_nxt = '0;
                    end else if (key == KEY_SET_TIME || key == KEY_SET_ALARM) begin
                        w_key_err_nxt = 1'b1;
                    end
                end else if (r_state == S_ENTRY && r_tmo == TMO_LAST) begin
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = S_CLEAR;
                    w_shift_nxt   = 1'b1;
                    w_clr_cnt_nxt = '0;
                end
            end
            S_READY: begin
                if (key_valid) begin
                    if (w_is_digit) begin
                        w_key_err_nxt = 1'b1;
                    end else if (key == KEY_SET_TIME) begin
                        w_load_time_nxt = 1'b1;
                        w_state_nxt     = S_LOAD;
                    end else if (key == KEY_SET_ALARM) begin
                        w_load_alarm_nxt = 1'b1;
                        w_state_nxt      = S_LOAD;
                    end else if (key == KEY_CLEAR) begin
                        w_state_nxt   = S_CLEAR;
                        w_shift_nxt   = 1'b1;
                        w_clr_cnt_nxt = '0;
                    end
                end else if (r_tmo == TMO_LAST) begin
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = S_CLEAR;
                    w_shift_nxt   = 1'b1;
                    w_clr_cnt_nxt = '0;
                end
            end
            S_LOAD: begin
                w_state_nxt   = S_CLEAR;
                w_shift_nxt   = 1'b1;
                w_clr_cnt_nxt = '0;
            end
            S_CLEAR: begin
                // first zero-shift is issued on entry; three more follow here
                if (r_clr_cnt == CLR_W'(3)) begin
                    w_state_nxt     = S_IDLE;
                    w_digit_cnt_nxt = '0;
                    w_clr_cnt_nxt   = '0;
                end else begin
                    w_shift_nxt   = 1'b1;
                    w_clr_cnt_nxt = r_clr_cnt + CLR_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_in_entry     = (r_state == S_ENTRY) || (r_state == S_READY);
    assign w_nxt_in_entry = (w_state_nxt == S_ENTRY) || (w_state_nxt == S_READY);

    // inactivity counter: any strobe or leaving ENTRY/READY restarts it
    always_comb begin
        w_tmo_nxt = '0;
        if (w_in_entry && w_nxt_in_entry && !key_valid) begin
            w_tmo_nxt = r_tmo + TMO_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_shift      <= 1'b0;
            r_key_out    <= '0;
            r_load_time  <= 1'b0;
            r_load_alarm <= 1'b0;
            r_key_err    <= 1'b0;
            r_timeout    <= 1'b0;
            r_digit_cnt  <= '0;
            r_first      <= '0;
            r_tmo        <= '0;
            r_clr_cnt    <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_shift      <= w_shift_nxt;
            r_key_out    <= w_key_out_nxt;
            r_load_time  <= w_load_time_nxt;
            r_load_alarm <= w_load_alarm_nxt;
            r_key_err    <= w_key_err_nxt;
            r_timeout    <= w_timeout_nxt;
            r_digit_cnt  <= w_digit_cnt_nxt;
            r_first      <= w_first_nxt;
            r_tmo        <= w_tmo_nxt;
            r_clr_cnt    <= w_clr_cnt_nxt;
        end
    end

    assign shift      = r_shift;
    assign key_out    = r_key_out;
    assign load_time  = r_load_time;
    assign load_alarm = r_load_alarm;
    assign key_err    = r_key_err;
    assign timeout    = r_timeout;
    assign digit_cnt  = r_digit_cnt;

endmodule

// File: tb/tb_key_entry_ctrl.sv
// Bench for key_entry_ctrl: directed scenarios plus random key traffic checked
// against a queue-based model of the entry rules.
module tb_key_entry_ctrl;

    localparam int unsigned T = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] key;
    logic       key_valid;
    logic       shift;
    logic [3:0] key_out;
    logic       load_time;
    logic       load_alarm;
    logic       key_err;
    logic       timeout;
    logic [2:0] digit_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    key_entry_ctrl #(.TIMEOUT_CYCLES(T), .TMO_W(5)) dut (
        .clk(clk), .reset(reset), .key(key), .key_valid(key_valid),
        .shift(shift), .key_out(key_out), .load_time(load_time),
        .load_alarm(load_alarm), .key_err(key_err), .timeout(timeout),
        .digit_cnt(digit_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1);
    end

    // Reference model: digits entered so far, plus a schedule of forced
    // outputs (0=end of flush, 1=zero shift) during which keys are ignored.
    int         m_digits[$];
    int         m_sched[$];
    int         m_quiet;
    logic       e_shift, e_lt, e_la, e_err, e_tmo;
    logic [3:0] e_kout;

    function automatic logic [11:0] act_v();
        return {shift, key_out, load_time, load_alarm, key_err, timeout, digit_cnt};
    endfunction

    function automatic logic [11:0] exp_v();
        return {e_shift, e_kout, e_lt, e_la, e_err, e_tmo, 3'(m_digits.size())};
    endfunction

    function automatic logic digit_ok(input logic [3:0] k);
        int lim;
        case (m_digits.size())
            0:       lim = 2;
            1:       lim = (m_digits[0] == 2) ? 3 : 9;
            2:       lim = 5;
            3:       lim = 9;
            default: lim = -1;
        endcase
        return int'(k) <= lim;
    endfunction

    task automatic start_flush(input int extra);
        e_shift = 1'b1;
        for (int i = 0; i < extra; i++) m_sched.push_back(1);
        m_sched.push_back(0);
        m_quiet = 0;
    endtask

    task automatic model_step(input logic v, input logic [3:0] k);
        int code;
        {e_shift, e_lt, e_la, e_err, e_tmo} = '0;
        e_kout = 4'h0;
        if (m_sched.size() > 0) begin
            code = m_sched.pop_front();
            if (code == 1) e_shift = 1'b1;
            else m_digits.delete();
        end else if (v) begin
            m_quiet = 0;
            if (k <= 4'd9) begin
                if (m_digits.size() < 4 && digit_ok(k)) begin
                    m_digits.push_back(int'(k));
                    e_shift = 1'b1;
                    e_kout  = k;
                end else begin
                    e_err = 1'b1;
                end
            end else if (k == 4'hA) begin
                start_flush(3);
            end else if (k == 4'hB || k == 4'hC) begin
                if (m_digits.size() == 4) begin
                    if (k == 4'hB) e_lt = 1'b1;
                    else e_la = 1'b1;
                    for (int i = 0; i < 4; i++) m_sched.push_back(1);
                    m_sched.push_back(0);
                end else begin
                    e_err = 1'b1;
                end
            end
        end else if (m_digits.size() > 0) begin
            if (m_quiet == int'(T) - 1) begin
                e_tmo = 1'b1;
                start_flush(3);
            end else begin
                m_quiet++;
            end
        end
    endtask

    task automatic tick(input logic v, input logic [3:0] k);
        @(negedge clk);
        reset = 1'b1; key_valid = v; key = k;
        @(posedge clk);
        model_step(v, k);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0; key_valid = 1'b0; key = 4'h0;
        @(posedge clk);
        m_digits.delete(); m_sched.delete(); m_quiet = 0;
        {e_shift, e_lt, e_la, e_err, e_tmo} = '0;
        e_kout = 4'h0;
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        n_tests++;
        if (act_v() !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_state: got %h exp 000", act_v());
        end
    endtask

    task automatic test_time_load();
        logic [3:0] seq[5] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'hB};
        int shifts = 0;
        for (int i = 0; i < 5; i++) begin
            for (int g = 0; g < 3; g++) begin
                tick(g == 0, seq[i]);
                if (shift) shifts++;
                n_tests++;
                if (act_v() !== exp_v()) begin
                    n_fail++;
                    $display("FAIL time_load key%0d+%0d: got %h exp %h", i, g, act_v(), exp_v());
                end
                if (i == 4 && g == 0) begin
                    n_tests++;
                    if (load_time !== 1'b1 || digit_cnt !== 3'd4) begin
                        n_fail++;
                        $display("FAIL time_load_pulse: lt=%b cnt=%0d exp lt=1 cnt=4", load_time, digit_cnt);
                    end
                end
            end
        end
        for (int c = 0; c < 4; c++) begin
            tick(1'b0, 4'h0);
            if (shift) shifts++;
            n_tests++;
            if (act_v() !== exp_v()) begin
                n_fail++;
                $display("FAIL time_load flush%0d: got %h exp %h", c, act_v(), exp_v());
            end
        end
        n_tests++;
        if (shifts !== 8 || digit_cnt !== 3'd0) begin
            n_fail++;
            $display("FAIL time_load_total: shifts=%0d cnt=%0d exp 8/0", shifts, digit_cnt);
        end
    endtask

    task automatic test_alarm_entry();
        logic [3:0] seq[8] = '{4'h3, 4'h2, 4'h4, 4'h3, 4'h5, 4'h9, 4'hC, 4'h0};
        for (int i = 0; i < 8; i++) begin
            tick(i < 7, seq[i]);
            n_tests++;
            if (act_v() !== exp_v()) begin
                n_fail++;
                $display("FAIL alarm_entry step%0d: got %h exp %h", i, act_v(), exp_v());
            end
            if (i == 0 || i == 2) begin
                n_tests++;
                if (key_err !== 1'b1 || shift !== 1'b0) begin
                    n_fail++;
                    $display("FAIL alarm_reject%0d: err=%b shift=%b exp 1/0", i, key_err, shift);
                end
            end
        end
        for (int c = 0; c < 5; c++) tick(1'b0, 4'h0);
    endtask

    task automatic test_pos2_reject();
        logic [3:0] seq[7] = '{4'h1, 4'h9, 4'h6, 4'h5, 4'h0, 4'h7, 4'hA};
        for (int i = 0; i < 7; i++) begin
            tick(1'b1, seq[i]);
            n_tests++;
            if (act_v() !== exp_v()) begin
                n_fail++;
                $display("FAIL pos2 step%0d: got %h exp %h", i, act_v(), exp_v());
            end
        end
        n_tests++;
        if (digit_cnt !== 3'd4) begin
            n_fail++;
            $display("FAIL pos2_ready_cnt: got %0d exp 4", digit_cnt);
        end
        for (int c = 0; c < 5; c++) tick(1'b0, 4'h0);
    endtask

    task automatic test_timeout();
        int at = -1;
        int shifts = 0;
        tick(1'b1, 4'h1);
        for (int c = 1; c <= 40 && at < 0; c++) begin
            tick(1'b0, 4'h0);
            n_tests++;
            if (act_v() !== exp_v()) begin
                n_fail++;
                $display("FAIL timeout cyc%0d: got %h exp %h", c, act_v(), exp_v());
            end
            if (timeout === 1'b1) begin
                at = c;
                if (shift) shifts++;
            end
        end
        n_tests++;
        if (at != int'(T)) begin
            n_fail++;
            $display("FAIL timeout_delay: got %0d exp %0d", at, T);
        end
        for (int c = 0; c < 4; c++) begin
            tick(1'b0, 4'h0);
            if (shift) shifts++;
        end
        n_tests++;
        if (shifts != 4 || digit_cnt !== 3'd0) begin
            n_fail++;
            $display("FAIL timeout_flush: shifts=%0d cnt=%0d exp 4/0", shifts, digit_cnt);
        end
    endtask

    task automatic test_clear_drop();
        logic [3:0] seq[8] = '{4'h2, 4'h1, 4'hA, 4'h7, 4'h0, 4'h0, 4'h0, 4'h1};
        logic       vld[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 8; i++) begin
            tick(vld[i], seq[i]);
            n_tests++;
            if (act_v() !== exp_v()) begin
                n_fail++;
                $display("FAIL clear_drop step%0d: got %h exp %h", i, act_v(), exp_v());
            end
        end
        n_tests++;
        if (shift !== 1'b1 || key_out !== 4'h1 || digit_cnt !== 3'd1) begin
            n_fail++;
            $display("FAIL clear_first_key: shift=%b out=%h cnt=%0d exp 1/1/1", shift, key_out, digit_cnt);
        end
        tick(1'b1, 4'hA);
        for (int c = 0; c < 4; c++) tick(1'b0, 4'h0);
    endtask

    task automatic test_reset_mid_clear();
        tick(1'b1, 4'h1);
        tick(1'b1, 4'hA);
        tick(1'b0, 4'h0);
        apply_reset();
        n_tests++;
        if (act_v() !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_mid_clear: got %h exp 000", act_v());
        end
        tick(1'b1, 4'h0);
        n_tests++;
        if (act_v() !== exp_v() || shift !== 1'b1 || digit_cnt !== 3'd1) begin
            n_fail++;
            $display("FAIL reset_then_digit0: got %h exp %h", act_v(), exp_v());
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] seq[7] = '{4'h2, 4'h3, 4'h5, 4'h9, 4'hC, 4'hB, 4'h1};
        for (int i = 0; i < 12; i++) begin
            tick(i < 7, (i < 7) ? seq[i] : 4'h0);
            n_tests++;
            if (act_v() !== exp_v()) begin
                n_fail++;
                $display("FAIL back_to_back step%0d: got %h exp %h", i, act_v(), exp_v());
            end
        end
    endtask

    task automatic test_random();
        logic       v;
        logic [3:0] k;
        int         quiet = 0;
        for (int i = 0; i < 1500; i++) begin
            if (quiet > 0) begin
                quiet--;
                v = 1'b0;
            end else begin
                v = ($urandom_range(0, 2) == 0);
                if ($urandom_range(0, 40) == 0) quiet = $urandom_range(10, 24);
            end
            case ($urandom_range(0, 9))
                0, 1, 2:    k = 4'($urandom_range(0, 2));
                3, 4, 5, 6: k = 4'($urandom_range(0, 9));
                7:          k = 4'hA;
                default:    k = 4'($urandom_range(11, 15));
            endcase
            tick(v, k);
            n_tests++;
            if (act_v() !== exp_v()) begin
                n_fail++;
                $display("FAIL random cyc%0d v=%b k=%h: got %h exp %h", i, v, k, act_v(), exp_v());
            end
        end
    endtask

    initial begin
        reset = 1'b0; key_valid = 1'b0; key = 4'h0;
        m_quiet = 0;
        {e_shift, e_lt, e_la, e_err, e_tmo} = '0;
        e_kout = 4'h0;
        test_reset();
        test_time_load();
        test_alarm_entry();
        test_pos2_reject();
        test_timeout();
        test_clear_drop();
        test_reset_mid_clear();
        test_reset();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/key_entry_ctrl.md
Name: key_entry_ctrl

Overview:
- Sequences the 4-digit key shift register (HH:MM buffer) for the alarm clock.
- Takes decoded keypad strobes and range-checks each digit against its HH:MM position; only accepted digits become a one-cycle shift with the digit on key_out.
- Issues load pulses to the time or alarm core once four digits are present, then clears the buffer by shifting in four zeros.
- Aborts an entry on a clear key or on an inactivity timeout.

Parameters:
- TIMEOUT_CYCLES, 50_000_000, idle cycles allowed in ENTRY/READY before abort.
- TMO_W, 26, width of the timeout counter; must satisfy 2^TMO_W > TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- key  input  4  decoded key code: 0-9 digit, 4'hA clear, 4'hB set time, 4'hC set alarm, 4'hD-4'hF unused.
- key_valid  input  1  one-cycle strobe; key is meaningful only when high.
- shift  output  1  registered shift enable to the key buffer.
- key_out  output  4  registered digit shifted into the least-significant-minute slot; valid when shift=1.
- load_time  output  1  one-cycle pulse: buffer holds a valid time; time core captures it.
- load_alarm  output  1  one-cycle pulse: buffer holds a valid alarm; alarm core captures it.
- key_err  output  1  one-cycle pulse: key rejected.
- timeout  output  1  one-cycle pulse: entry aborted by inactivity.
- digit_cnt  output  3  digits accepted in the current entry, 0-4.

Behaviour:
- Reset (reset=0 at a clock edge): state IDLE, all outputs 0, digit_cnt=0, internal first-digit register 0, timeout counter 0.
  - Applies from any state, including mid-CLEAR. Remaining zero-shifts are abandoned.
  - The key buffer is cleared by its own reset.
- All outputs are registered. A response to key_valid at edge N appears in cycle N+1.
- States: IDLE, ENTRY, READY, LOAD, CLEAR.
- Digit acceptance by position (digit_cnt before the key):
  - pos0: 0-2.
  - pos1: 0-9, or 0-3 when the stored first digit is 2.
  - pos2: 0-5.
  - pos3: 0-9.
  - An accepted digit gives shift=1, key_out=key, digit_cnt+1.
  - A digit at pos0 is stored as the first digit.
  - A rejected digit gives key_err=1, no shift, no state change.
- IDLE:
  - Accepted digit -> ENTRY (digit_cnt=1).
  - 4'hA -> CLEAR.
  - 4'hB or 4'hC -> key_err.
  - 4'hD-4'hF ignored silently.
- ENTRY:
  - Accepted digit shifts. If digit_cnt becomes 4 -> READY.
  - 4'hB or 4'hC -> key_err, stay.
  - 4'hA -> CLEAR.
- READY:
  - Any digit -> key_err, no shift.
  - 4'hB -> LOAD with load_time=1.
  - 4'hC -> LOAD with load_alarm=1.
  - 4'hA -> CLEAR.
- LOAD: one cycle.
  - load_time or load_alarm is high while the buffer is unchanged.
  - The next cycle enters CLEAR.
- CLEAR:
  - Exactly 4 consecutive cycles of shift=1, key_out=0.
  - Then IDLE with digit_cnt=0.
  - key_valid during CLEAR or LOAD is dropped: no key_err, no shift.
  - Timing: clear key at edge N gives shift cycles N+1..N+4, IDLE at N+5. The first key accepted is at edge N+5.
- Timeout counter:
  - Counts only in ENTRY and READY.
  - Clears to 0 on any key_valid (accepted, rejected or ignored) and on leaving those states.
  - When the counter equals TIMEOUT_CYCLES-1 with no key_valid that cycle: timeout=1, go to CLEAR.
  - If key_valid coincides with expiry, the key is processed and the counter clears; no timeout.
- digit_cnt saturates at 4 and returns to 0 only on entering IDLE from CLEAR, or on reset.
- shift, load_time, load_alarm, key_err and timeout are never high for more than one cycle per event, except shift during CLEAR.

Test Plan:
- Keys 1,2,3,4 then B, spaced 3 cycles apart -> four shift pulses with key_out 1,2,3,4 and digit_cnt 1..4; load_time one cycle after B; then 4 zero-shifts; IDLE.
- First key 3 -> key_err, no shift, digit_cnt=0. Then 2,4 -> 4 rejected with key_err. Then 3,5,9 accepted -> READY. Key C -> load_alarm.
- Keys 1,9,6 -> 6 rejected at pos2. Then 5 accepted. Then 0 accepted -> READY. A digit in READY -> key_err.
- TIMEOUT_CYCLES=16: key 1, then no key -> timeout pulse 16 cycles after the key, then 4 zero-shifts, IDLE, digit_cnt=0.
- Keys 2,1 then A -> CLEAR. A key 7 strobed in the second CLEAR cycle is dropped with no key_err. Key 1 at edge N+5 is accepted.
- reset=0 during the 2nd CLEAR shift cycle -> next cycle shift=0, all outputs 0, IDLE. Digit 0 after reset is accepted.
